// File: rtl/dmem_mmio.sv
// dmem_mmio: word-addressed data RAM plus memory-mapped cycle counter, timer and LED register
module dmem_mmio #(
  parameter int RAM_AW = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwriteM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic [7:0]  led,
  output logic        irq
);
  logic [31:0] ram [2**RAM_AW];
  logic [31:0] cycle, cmp, cnt, mmio_rd;
  logic [2:0]  ctrl, sel;
  logic        flag, in_ram, in_mmio, match;
  logic        wr_cmp, wr_ctrl, wr_cnt, wr_status, wr_led;
  logic [RAM_AW-1:0] widx;
  logic        unused_lsb;
  assign unused_lsb = ^aluoutM[1:0];
  assign in_ram    = ~|aluoutM[31:RAM_AW+2];
  assign in_mmio   = aluoutM[31:16] == 16'hFFFF;
  assign widx      = aluoutM[RAM_AW+1:2];
  assign sel       = aluoutM[4:2];
  assign wr_cmp    = memwriteM & in_mmio & (sel == 3'd1);
  assign wr_ctrl   = memwriteM & in_mmio & (sel == 3'd2);
  assign wr_cnt    = memwriteM & in_mmio & (sel == 3'd3);
  assign wr_status = memwriteM & in_mmio & (sel == 3'd4);
  assign wr_led    = memwriteM & in_mmio & (sel == 3'd5);
  assign match     = ctrl[0] & (cnt == cmp);
  assign irq       = flag & ctrl[2];
  always_ff @(posedge clk)
    if (memwriteM & in_ram & ~reset) ram[widx] <= writedataM;
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle <= '0;
      cmp   <= '0;
      ctrl  <= '0;
      cnt   <= '0;
      flag  <= 1'b0;
      led   <= '0;
    end else begin
      cycle <= cycle + 32'd1;
      if (wr_cmp) cmp <= writedataM;
      if (wr_led) led <= writedataM[7:0];
      // a CPU write to CTRL beats the one-shot disable
      if (wr_ctrl) ctrl <= writedataM[2:0];
      else if (match & ~ctrl[1]) ctrl[0] <= 1'b0;
      if (wr_cnt) cnt <= writedataM;
      else if (match & ctrl[1]) cnt <= '0;
      else if (ctrl[0] & ~match) cnt <= cnt + 32'd1;
      if (match) flag <= 1'b1;
      else if (wr_status & writedataM[0]) flag <= 1'b0;
    end
  end
  always_comb begin
    mmio_rd   = sel == 3'd0 ? cycle :
                sel == 3'd1 ? cmp :
                sel == 3'd2 ? {29'd0, ctrl} :
                sel == 3'd3 ? cnt :
                sel == 3'd4 ? {31'd0, flag} :
                sel == 3'd5 ? {24'd0, led} : 32'd0;
    readdataM = in_ram ? ram[widx] : in_mmio ? mmio_rd : 32'd0;
  end
endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed and random checks of dmem_mmio against a rule-level reference model
module tb_dmem_mmio;
  logic        clk, reset, memwriteM, irq;
  logic [31:0] aluoutM, writedataM, readdataM;
  logic [7:0]  led;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] m_ram [64];
  bit          m_known [64];
  logic [31:0] m_cycle, m_cmp, m_cnt;
  logic        m_en, m_ar, m_ie, m_flag, m_init = 1'b0;
  logic [7:0]  m_led;
  localparam logic [31:0] CYC = 32'hFFFF0000, CMP = 32'hFFFF0004, CTL = 32'hFFFF0008,
                          CNT = 32'hFFFF000C, STA = 32'hFFFF0010, LED = 32'hFFFF0014;
  dmem_mmio #(.RAM_AW(6)) dut (.clk(clk), .reset(reset), .memwriteM(memwriteM), .aluoutM(aluoutM),
    .writedataM(writedataM), .readdataM(readdataM), .led(led), .irq(irq));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mread(input logic [31:0] a);
    if (a[31:8] == 24'd0) return m_ram[a[7:2]];
    if (a[31:16] != 16'hFFFF) return 32'd0;
    case (a[4:2])
      3'd0: return m_cycle;
      3'd1: return m_cmp;
      3'd2: return {29'd0, m_ie, m_ar, m_en};
      3'd3: return m_cnt;
      3'd4: return {31'd0, m_flag};
      3'd5: return {24'd0, m_led};
      default: return 32'd0;
    endcase
  endfunction
  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rst);
    memwriteM = we; aluoutM = a; writedataM = d; reset = rst;
    #1;
    if (m_init) begin
      if (a[31:8] != 24'd0 || m_known[a[7:2]]) chk("rd", readdataM, mread(a));
      chk("led", {24'd0, led}, {24'd0, m_led});
      chk("irq", {31'd0, irq}, {31'd0, m_flag & m_ie});
    end
  endtask
  task automatic model();
    logic mt, mw;
    logic [2:0] s;
    if (reset) begin
      m_cycle = 0; m_cmp = 0; m_cnt = 0; m_led = 0;
      {m_ie, m_ar, m_en, m_flag} = 4'b0;
      m_init = 1'b1;
      return;
    end
    mt = m_en && m_cnt == m_cmp;
    mw = memwriteM && aluoutM[31:16] == 16'hFFFF;
    s  = aluoutM[4:2];
    if (memwriteM && aluoutM[31:8] == 24'd0) begin
      m_ram[aluoutM[7:2]] = writedataM;
      m_known[aluoutM[7:2]] = 1'b1;
    end
    m_cycle = m_cycle + 1;
    if (mw && s == 3'd1) m_cmp = writedataM;
    if (mw && s == 3'd3) m_cnt = writedataM;
    else if (mt) m_cnt = m_ar ? 32'd0 : m_cnt;
    else if (m_en) m_cnt = m_cnt + 1;
    if (mw && s == 3'd2) {m_ie, m_ar, m_en} = writedataM[2:0];
    else if (mt && !m_ar) m_en = 1'b0;
    if (mt) m_flag = 1'b1;
    else if (mw && s == 3'd4 && writedataM[0]) m_flag = 1'b0;
    if (mw && s == 3'd5) m_led = writedataM[7:0];
  endtask
  task automatic step();
    @(posedge clk);
    model();
    @(negedge clk);
  endtask
  initial begin
    logic [31:0] a, d;
    logic rst, we;
    drive(0, CYC, 0, 1); step();
    drive(0, CYC, 0, 1); step();
    for (int i = 0; i < 64; i++) begin drive(1, 32'(i * 4), $urandom, 0); step(); end
    drive(1, 32'h10, 32'hDEADBEEF, 0); step();
    drive(0, 32'h10, 0, 0); chk("ram_10", readdataM, 32'hDEADBEEF); step();
    drive(0, 32'h13, 0, 0); chk("ram_13", readdataM, 32'hDEADBEEF); step();
    drive(0, 32'h110, 0, 0); chk("out_rd", readdataM, 32'd0); step();
    drive(1, 32'h110, 32'h55, 0); step();
    drive(0, 32'h10, 0, 0); chk("out_wr", readdataM, 32'hDEADBEEF); step();
    drive(0, CYC, 0, 1); step();
    drive(0, CYC, 0, 0); chk("cyc_k", readdataM, 32'd0); step();
    for (int i = 1; i < 5; i++) begin drive(0, CYC, 0, 0); step(); end
    drive(0, CYC, 0, 0); chk("cyc_k5", readdataM, 32'd5); step();
    drive(1, CYC, 32'h1234, 0); chk("cyc_ro", readdataM, 32'd6); step();
    drive(0, CYC, 0, 0); chk("cyc_ro2", readdataM, 32'd7); step();
    drive(1, CMP, 3, 0); step();
    drive(1, CNT, 0, 0); step();
    drive(1, CTL, 5, 0); step();
    for (int i = 0; i < 4; i++) begin
      drive(0, CNT, 0, 0); chk("os_cnt", readdataM, 32'(i)); chk("os_noirq", {31'd0, irq}, 32'd0); step();
    end
    drive(0, STA, 0, 0); chk("os_flag", readdataM, 32'd1); chk("os_irq", {31'd0, irq}, 32'd1); step();
    drive(0, CTL, 0, 0); chk("os_ctrl", readdataM, 32'd4); step();
    drive(0, CNT, 0, 0); chk("os_hold", readdataM, 32'd3); step();
    drive(1, STA, 1, 0); step();
    drive(0, STA, 0, 0); chk("w1c_irq", {31'd0, irq}, 32'd0); step();
    drive(1, CMP, 2, 0); step();
    drive(1, CNT, 0, 0); step();
    drive(1, CTL, 3, 0); step();
    for (int i = 0; i < 6; i++) begin
      drive(0, CNT, 0, 0); chk("ar_cnt", readdataM, 32'(i % 3)); chk("ar_noirq", {31'd0, irq}, 32'd0); step();
    end
    drive(0, STA, 0, 0); chk("ar_flag", readdataM, 32'd1); step();
    drive(1, CTL, 0, 0); step();
    drive(1, STA, 1, 0); step();
    drive(1, CMP, 4, 0); step();
    drive(1, CNT, 4, 0); step();
    drive(1, CTL, 5, 0); step();
    drive(1, STA, 1, 0); step();
    drive(0, STA, 0, 0); chk("set_wins", readdataM, 32'd1); chk("set_irq", {31'd0, irq}, 32'd1); step();
    drive(1, CTL, 3, 0); step();
    drive(1, CNT, 7, 0); step();
    drive(0, CNT, 0, 0); chk("cnt_wr", readdataM, 32'd7); step();
    drive(0, STA, 0, 0); chk("cnt_wr_flag", readdataM, 32'd1); step();
    drive(1, CTL, 7, 0); step();
    drive(1, CNT, 5, 0); step();
    drive(1, LED, 32'hA5, 0); step();
    drive(0, STA, 0, 0); chk("pre_led", {24'd0, led}, 32'hA5); chk("pre_irq", {31'd0, irq}, 32'd1); step();
    drive(0, CTL, 0, 1); step();
    for (int i = 0; i < 6; i++) begin
      drive(0, CYC + 32'(i * 4), 0, 0);
      chk("rst_reg", readdataM, i == 0 ? 32'd0 : 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk("rst_led", {24'd0, led}, 32'd0);
      step();
    end
    drive(0, 32'h10, 0, 0); chk("rst_ram", readdataM, 32'hDEADBEEF); step();
    for (int i = 0; i < 800; i++) begin
      rst = $urandom_range(0, 99) < 2;
      we  = !rst && $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 9))
        0, 1, 2: a = {24'd0, 8'($urandom)};
        3:       a = $urandom;
        default: a = {16'hFFFF, 11'($urandom), 3'($urandom_range(0, 7)), 2'($urandom)};
      endcase
      d = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 7));
      drive(we, a, d, rst); step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
